// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between an EXU port (0) and an LSU port (1),
// with a one-deep registered response buffer per port. Optional opcode check: ALU_ARB_OPCHK_EN.

`ifndef ALU_ADD
`define ALU_ADD  4'd0
`define ALU_SUB  4'd1
`define ALU_AND  4'd2
`define ALU_OR   4'd3
`define ALU_XOR  4'd4
`define ALU_SLT  4'd5
`define ALU_SLTU 4'd6
`define ALU_SLL  4'd7
`define ALU_SRL  4'd8
`define ALU_SRA  4'd9
`endif

module alu_arbiter #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned INIT_PRIO = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [3:0]      req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  output logic            rsp0_valid,
  input  logic            rsp0_ready,
  output logic [XLEN-1:0] rsp0_result,
  output logic            rsp0_zero,
  output logic            rsp0_less,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [3:0]      req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic            rsp1_valid,
  input  logic            rsp1_ready,
  output logic [XLEN-1:0] rsp1_result,
  output logic            rsp1_zero,
  output logic            rsp1_less,
  output logic [3:0]      alu_op,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero,
  input  logic            alu_less,
  output logic            busy
`ifdef ALU_ARB_OPCHK_EN
  ,
  output logic            rsp0_illegal,
  output logic            rsp1_illegal
`endif
);

  typedef enum logic {
    PRIO_P0 = 1'b0,
    PRIO_P1 = 1'b1
  } prio_e;

  localparam prio_e PRIO_RST = (INIT_PRIO == 0) ? PRIO_P0 : PRIO_P1;

  prio_e           prio_q;
  prio_e           prio_d;
  logic            free0, free1;
  logic            elig0, elig1;
  logic            grant0, grant1, any_grant;
  logic [3:0]      sel_op;
  logic [XLEN-1:0] sel_a, sel_b;
  logic            op_illegal;

`ifdef ALU_ARB_OPCHK_EN
  function automatic logic op_is_legal(input logic [3:0] op);
    return (op <= `ALU_SRA);
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (rst) prio_q <= PRIO_RST;
    else     prio_q <= prio_d;
  end

  always_comb begin
    prio_d = prio_q;
    if (grant0)      prio_d = PRIO_P1;
    else if (grant1) prio_d = PRIO_P0;
  end

  // A full buffer being drained this cycle counts as free, so a port can stream at one op per cycle.
  always_comb begin
    free0     = ~rsp0_valid | rsp0_ready;
    free1     = ~rsp1_valid | rsp1_ready;
    elig0     = req0_valid & free0;
    elig1     = req1_valid & free1;
    grant0    = elig0 & (~elig1 | (prio_q == PRIO_P0));
    grant1    = elig1 & (~elig0 | (prio_q == PRIO_P1));
    any_grant = grant0 | grant1;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    if (grant1 || (!grant0 && prio_q == PRIO_P1)) begin
      sel_op = req1_op;
      sel_a  = req1_a;
      sel_b  = req1_b;
    end else begin
      sel_op = req0_op;
      sel_a  = req0_a;
      sel_b  = req0_b;
    end
    op_illegal = 1'b0;
`ifdef ALU_ARB_OPCHK_EN
    op_illegal = any_grant & ~op_is_legal(sel_op);
`endif
    alu_op = (any_grant && !op_illegal) ? sel_op : `ALU_ADD;
    alu_a  = sel_a;
    alu_b  = sel_b;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp0_valid  <= 1'b0;
      rsp0_result <= '0;
      rsp0_zero   <= 1'b0;
      rsp0_less   <= 1'b0;
      rsp1_valid  <= 1'b0;
      rsp1_result <= '0;
      rsp1_zero   <= 1'b0;
      rsp1_less   <= 1'b0;
`ifdef ALU_ARB_OPCHK_EN
      rsp0_illegal <= 1'b0;
      rsp1_illegal <= 1'b0;
`endif
    end else begin
      if (grant0) begin
        rsp0_valid  <= 1'b1;
        rsp0_result <= op_illegal ? '0 : alu_result;
        rsp0_zero   <= op_illegal | alu_zero;
        rsp0_less   <= ~op_illegal & alu_less;
`ifdef ALU_ARB_OPCHK_EN
        rsp0_illegal <= op_illegal;
`endif
      end else if (rsp0_ready) begin
        rsp0_valid <= 1'b0;
      end
      if (grant1) begin
        rsp1_valid  <= 1'b1;
        rsp1_result <= op_illegal ? '0 : alu_result;
        rsp1_zero   <= op_illegal | alu_zero;
        rsp1_less   <= ~op_illegal & alu_less;
`ifdef ALU_ARB_OPCHK_EN
        rsp1_illegal <= op_illegal;
`endif
      end else if (rsp1_ready) begin
        rsp1_valid <= 1'b0;
      end
    end
  end

  assign busy = rsp0_valid | rsp1_valid;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by random traffic, all checked
// against a transaction-level model (per-port buffer records, round-robin pointer, reference ALU).
module tb_alu_arbiter;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLT  = 4'd5;
  localparam logic [3:0] OP_SLTU = 4'd6;
  localparam logic [3:0] OP_SLL  = 4'd7;
  localparam logic [3:0] OP_SRL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam int         INIT_P  = 0;
`ifdef ALU_ARB_OPCHK_EN
  localparam bit OPCHK = 1'b1;
`else
  localparam bit OPCHK = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero, rsp0_less;
  logic        req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero, rsp1_less;
  logic [3:0]  req0_op, req1_op, alu_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, rsp0_result, rsp1_result;
  logic [31:0] alu_a, alu_b, alu_result;
  logic        alu_zero, alu_less, busy;
`ifdef ALU_ARB_OPCHK_EN
  logic        rsp0_illegal, rsp1_illegal;
`endif

  alu_arbiter #(.XLEN(32), .INIT_PRIO(INIT_P)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_zero(rsp0_zero), .rsp0_less(rsp0_less),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_zero(rsp1_zero), .rsp1_less(rsp1_less),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_less(alu_less),
    .busy(busy)
`ifdef ALU_ARB_OPCHK_EN
    , .rsp0_illegal(rsp0_illegal), .rsp1_illegal(rsp1_illegal)
`endif
  );

  // Reference ALU: {less, zero, result}
  function automatic logic [33:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        lt;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      OP_SLTU: r = (a < b) ? 32'd1 : 32'd0;
      OP_SLL:  r = a << b[4:0];
      OP_SRL:  r = a >> b[4:0];
      OP_SRA:  r = $signed(a) >>> b[4:0];
      default: r = 32'd0;
    endcase
    lt = (op == OP_SLTU) ? (a < b) : ($signed(a) < $signed(b));
    return {lt, (r == 32'd0), r};
  endfunction

  assign {alu_less, alu_zero, alu_result} = alu_fn(alu_op, alu_a, alu_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          valid;
    logic [31:0] result;
    bit          zero;
    bit          less;
    bit          illegal;
  } rsp_t;

  rsp_t mb[2];
  int   mprio;
  bit   known;
  int   n_total;
  int   n_pass;
  int   n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks the current cycle against the model, advances one clock, commits the model.
  task automatic cycle();
    bit          v[2], rr[2], e[2], g[2];
    logic [3:0]  op[2], eop;
    logic [31:0] a[2], b[2];
    logic [33:0] r;
    rsp_t        nb[2];
    int          src, np;
    bit          ill;
    #1;
    v[0] = req0_valid;  v[1] = req1_valid;
    rr[0] = rsp0_ready; rr[1] = rsp1_ready;
    op[0] = req0_op;    op[1] = req1_op;
    a[0] = req0_a;      a[1] = req1_a;
    b[0] = req0_b;      b[1] = req1_b;
    if (known) begin
      chk("rsp0_valid", rsp0_valid, mb[0].valid);
      chk("rsp1_valid", rsp1_valid, mb[1].valid);
      chk("busy", busy, mb[0].valid | mb[1].valid);
      if (mb[0].valid) begin
        chk("rsp0_result", rsp0_result, mb[0].result);
        chk("rsp0_zero", rsp0_zero, mb[0].zero);
        chk("rsp0_less", rsp0_less, mb[0].less);
`ifdef ALU_ARB_OPCHK_EN
        chk("rsp0_illegal", rsp0_illegal, mb[0].illegal);
`endif
      end
      if (mb[1].valid) begin
        chk("rsp1_result", rsp1_result, mb[1].result);
        chk("rsp1_zero", rsp1_zero, mb[1].zero);
        chk("rsp1_less", rsp1_less, mb[1].less);
`ifdef ALU_ARB_OPCHK_EN
        chk("rsp1_illegal", rsp1_illegal, mb[1].illegal);
`endif
      end
    end
    nb = mb;
    np = mprio;
    if (rst) begin
      for (int unsigned i = 0; i < 2; i++) nb[i] = '{0, 32'd0, 0, 0, 0};
      np = INIT_P;
      known = 1'b1;
    end else if (known) begin
      for (int unsigned i = 0; i < 2; i++) begin
        e[i] = v[i] && (!mb[i].valid || rr[i]);
        g[i] = 1'b0;
      end
      if (e[0] && e[1]) g[mprio] = 1'b1;
      else begin
        g[0] = e[0];
        g[1] = e[1];
      end
      src = g[0] ? 0 : (g[1] ? 1 : mprio);
      ill = OPCHK && (g[0] || g[1]) && (op[src] > OP_SRA);
      eop = ((g[0] || g[1]) && !ill) ? op[src] : OP_ADD;
      chk("req0_ready", req0_ready, g[0]);
      chk("req1_ready", req1_ready, g[1]);
      chk("alu_op", alu_op, eop);
      chk("alu_a", alu_a, a[src]);
      chk("alu_b", alu_b, b[src]);
      for (int unsigned i = 0; i < 2; i++) begin
        if (g[i]) begin
          if (ill) nb[i] = '{1, 32'd0, 1, 0, 1};
          else begin
            r = alu_fn(op[i], a[i], b[i]);
            nb[i] = '{1, r[31:0], r[32], r[33], 0};
          end
        end else if (rr[i]) begin
          nb[i].valid = 1'b0;
        end
      end
      if (g[0]) np = 1;
      else if (g[1]) np = 0;
    end
    @(posedge clk);
    mb = nb;
    mprio = np;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_operand();
    return ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 4));
  endfunction

  initial begin
    n_total = 0; n_pass = 0; n_fail = 0;
    known = 1'b0; mprio = INIT_P;
    for (int unsigned i = 0; i < 2; i++) mb[i] = '{0, 32'd0, 0, 0, 0};
    rst = 1'b1;
    req0_valid = 0; req0_op = OP_ADD; req0_a = 0; req0_b = 0; rsp0_ready = 0;
    req1_valid = 0; req1_op = OP_ADD; req1_a = 0; req1_b = 0; rsp1_ready = 0;
    cycle();
    cycle();
    chk("reset_rsp0_valid", rsp0_valid, 0);
    chk("reset_rsp1_valid", rsp1_valid, 0);
    chk("reset_rsp0_result", rsp0_result, 0);
    chk("reset_rsp1_result", rsp1_result, 0);
    chk("reset_busy", busy, 0);

    // 1: single ADD on port 0, then drain
    rst = 0;
    req0_valid = 1; req0_op = OP_ADD; req0_a = 5; req0_b = 7;
    #1 chk("t1_req0_ready", req0_ready, 1);
    cycle();
    req0_valid = 0; rsp0_ready = 1;
    chk("t1_rsp0_valid", rsp0_valid, 1);
    chk("t1_result", rsp0_result, 12);
    chk("t1_zero", rsp0_zero, 0);
    cycle();
    chk("t1_drained", rsp0_valid, 0);

    // 2: both ports every cycle, alternating grants from reset priority
    rst = 1; cycle(); rst = 0;
    rsp0_ready = 1; rsp1_ready = 1;
    req0_valid = 1; req0_op = OP_SUB; req0_a = 3; req0_b = 3;
    req1_valid = 1; req1_op = OP_SLT; req1_a = 32'hFFFF_FFFF; req1_b = 1;
    for (int unsigned i = 0; i < 4; i++) begin
      #1 chk("t2_req0_ready", req0_ready, (i % 2 == 0) ? 1 : 0);
      cycle();
      if (i == 0) begin
        chk("t2_rsp0_result", rsp0_result, 0);
        chk("t2_rsp0_zero", rsp0_zero, 1);
      end
      if (i == 1) begin
        chk("t2_rsp1_result", rsp1_result, 1);
        chk("t2_rsp1_less", rsp1_less, 1);
      end
    end

    // 3: port 1 back-pressure and pass-through refill
    req0_valid = 0; req1_valid = 0;
    cycle();
    rsp1_ready = 0;
    req1_valid = 1; req1_op = OP_SLTU; req1_a = 1; req1_b = 2;
    #1 chk("t3_first_ready", req1_ready, 1);
    cycle();
    req1_a = 5; req1_b = 3;
    req0_valid = 1; req0_op = OP_ADD; req0_a = 1; req0_b = 1;
    #1 chk("t3_blocked", req1_ready, 0);
    chk("t3_port0_granted", req0_ready, 1);
    cycle();
    cycle();
    chk("t3_held_result", rsp1_result, 1);
    rsp1_ready = 1;
    #1 chk("t3_passthru_ready", req1_ready, 1);
    cycle();
    chk("t3_still_valid", rsp1_valid, 1);
    chk("t3_new_result", rsp1_result, 0);

    // 4: shifts
    req1_valid = 0;
    req0_valid = 1; req0_op = OP_SRA; req0_a = 32'h8000_0000; req0_b = 32'h21;
    cycle();
    chk("t4_sra", rsp0_result, 32'hC000_0000);
    req0_op = OP_SLL; req0_a = 1; req0_b = 31;
    cycle();
    chk("t4_sll", rsp0_result, 32'h8000_0000);

    // 5: reset with both buffers full and a live port 1 request
    rsp0_ready = 0; rsp1_ready = 0;
    req0_op = OP_ADD; req0_a = 2; req0_b = 2;
    req1_valid = 1; req1_op = OP_ADD; req1_a = 3; req1_b = 3;
    cycle();
    cycle();
    chk("t5_both_full", {rsp1_valid, rsp0_valid}, 2'b11);
    rst = 1;
    cycle();
    rst = 0; req0_valid = 0; req1_valid = 0;
    #1 chk("t5_rsp0_cleared", rsp0_valid, 0);
    chk("t5_rsp1_cleared", rsp1_valid, 0);
    chk("t5_rsp1_result", rsp1_result, 0);
    req0_valid = 1; req1_valid = 1; rsp0_ready = 1; rsp1_ready = 1;
    #1 chk("t5_prio_p0", req0_ready, 1);
    chk("t5_prio_p1", req1_ready, 0);
    cycle();

    // 6: unknown opcode
    req1_valid = 0;
    req0_op = 4'hF; req0_a = 9; req0_b = 9;
    #1 chk("t6_accepted", req0_ready, 1);
`ifdef ALU_ARB_OPCHK_EN
    chk("t6_alu_op_forced", alu_op, OP_ADD);
    cycle();
    chk("t6_illegal", rsp0_illegal, 1);
    chk("t6_result", rsp0_result, 0);
    chk("t6_zero", rsp0_zero, 1);
`else
    chk("t6_alu_op_fwd", alu_op, 4'hF);
    cycle();
`endif

    // random traffic
    for (int unsigned n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      req0_valid = ($urandom_range(0, 3) != 0);
      req0_op = 4'($urandom_range(0, 15));
      req0_a = rand_operand(); req0_b = rand_operand();
      rsp0_ready = ($urandom_range(0, 2) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      req1_op = 4'($urandom_range(0, 15));
      req1_a = rand_operand(); req1_b = rand_operand();
      rsp1_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end
    rst = 0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU instance between two requesters: port 0 (EXU, integer ops) and port 1 (LSU, address generation and compare ops).
- Accepts at most one operation per cycle and drives the shared ALU with the granted operands.
- Registers the ALU outputs into a one-deep response buffer per requester.
- Returns results with a valid/ready handshake. Arbitration is round-robin.

Parameters:
- XLEN, 32, operand and result width.
- INIT_PRIO, 0, requester that holds priority after reset (0 or 1).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  port 0 request valid.
- req0_ready  out  1  port 0 request accepted this cycle.
- req0_op  in  4  port 0 ALU op, encoded per the `ALU_* defines.
- req0_a, req0_b  in  XLEN  port 0 operands.
- rsp0_valid  out  1  port 0 response buffer full.
- rsp0_ready  in  1  port 0 consumer takes the response.
- rsp0_result  out  XLEN  buffered result.
- rsp0_zero, rsp0_less  out  1  buffered flags.
- req1_* / rsp1_*  same set as port 0, for port 1.
- alu_op  out  4  to shared ALU.
- alu_a, alu_b  out  XLEN  to shared ALU.
- alu_result  in  XLEN  from shared ALU.
- alu_zero, alu_less  in  1  from shared ALU.
- busy  out  1  either response buffer full.

Behaviour:
- Reset: clk rising edge with rst=1 clears rsp0_valid, rsp1_valid, rsp*_result, rsp*_zero and rsp*_less to 0, and sets prio to INIT_PRIO. rst has priority over all other events, including a mid-handshake request.
- Eligibility: port i is eligible when reqi_valid=1 and its buffer is free. Free means rspi_valid=0, or rspi_valid=1 and rspi_ready=1 in the same cycle (pass-through drain).
- Grant:
  - If only one port is eligible, it is granted.
  - If both are eligible, port prio is granted.
  - After any grant, prio becomes the other port.
  - With no grant, prio holds.
- reqi_ready = grant_i (combinational). A handshake completes when valid and ready are both 1.
- ALU drive:
  - alu_op/alu_a/alu_b carry the granted port's fields.
  - With no grant they carry port prio's fields, and alu_op is forced to `ALU_ADD so the ALU default branch is never reached.
- Latency: one cycle. A request accepted at edge N yields rspi_valid=1 after edge N, with result, zero and less captured from the ALU at that edge.
- Response buffer (per port):
  - On rspi_valid & rspi_ready with no new grant, rspi_valid goes to 0.
  - With a new grant the same cycle, the buffer is overwritten and rspi_valid stays 1.
  - Data is held stable while rspi_valid=1 and rspi_ready=0.
- Ordering: in-order per port. Two ports are independent; both buffers may be full simultaneously.
- No combinational path from rspi_ready to alu_* except through grant eligibility.
- Operands pass unmodified; width rules are those of the ALU (shift amount b[4:0]).
- busy = rsp0_valid | rsp1_valid.

Optional Feature:
- Macro: ALU_ARB_OPCHK_EN.
- When defined, each port adds an output rspi_illegal (1 bit), reset 0.
  - A granted request whose op is not one of ADD, SUB, AND, OR, XOR, SLT, SLTU, SLL, SRL, SRA is still accepted (reqi_ready=1).
  - alu_op is forced to `ALU_ADD.
  - The buffer captures result=0, zero=1, less=0 and rspi_illegal=1.
  - Legal ops capture rspi_illegal=0.
- When undefined, the op is forwarded unchecked and no rspi_illegal port exists.

Test Plan:
1. Reset, then port 0 only: op=ADD, a=5, b=7 -> req0_ready=1 that cycle; next cycle rsp0_valid=1, result=12, zero=0. With rsp0_ready=1 the following cycle, rsp0_valid returns to 0.
2. Both ports valid every cycle with INIT_PRIO=0; port 0 SUB 3-3, port 1 SLT a=0xFFFFFFFF, b=1; both consumers always ready -> grants alternate 0,1,0,1. Port 0 result=0, zero=1; port 1 result=1, less=1.
3. Port 1 back-pressure: rsp1_ready=0, port 1 issues SLTU 1<2 then a second request -> first accepted; second sees req1_ready=0 and port 0 requests are granted meanwhile. Raising rsp1_ready lets the second be accepted the same cycle (pass-through); rsp1_valid stays 1 with the new data.
4. Shift ops: port 0 SRA a=0x80000000, b=0x21 -> result 0xC0000000 (b[4:0]=1). Then SLL a=1, b=31 -> result 0x80000000.
5. rst asserted the cycle a port 1 request is valid and both buffers are full -> next cycle all rsp*_valid=0, prio=INIT_PRIO, no result captured.
6. (ALU_ARB_OPCHK_EN) port 0 op=4'b1111 -> accepted; alu_op=ADD; next cycle rsp0_valid=1, result=0, zero=1, rsp0_illegal=1. Without the macro, the bench checks the op is forwarded unchanged on alu_op.
